// File: rtl/mb_pkg.sv
// mb_pkg: shared types and constants for the math box microprogram sequencer
package mb_pkg;
    typedef enum logic {MB_IDLE = 1'b0, MB_RUN = 1'b1} mb_state_t;
    localparam int MB_ADDR_W = 8;
    localparam int MB_CNT_W = 12;
    localparam logic [7:0] MB_RESET_ADDR = 8'h00;
endpackage

// File: rtl/mb_upc_counter.sv
// mb_upc_counter: microcode program counter with load/increment/hold and natural wrap
module mb_upc_counter
    import mb_pkg::*;
#(
    parameter int ADDR_W = MB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] addr
);
    always_ff @(posedge clk) begin
        if (rst)
            addr <= ADDR_W'(MB_RESET_ADDR);
        else
            addr <= load ? load_addr : inc ? addr + 1'b1 : addr;
    end
endmodule

// File: rtl/mb_sequencer.sv
// mb_sequencer: math box microprogram sequencer (IDLE/RUN FSM, jump/stop, run counter).
// Optional MB_SINGLE_STEP_EN adds Step_Mode/Step gating of RUN advancement.
module mb_sequencer
    import mb_pkg::*;
#(
    parameter int ADDR_W = MB_ADDR_W,
    parameter int CNT_W  = MB_CNT_W
) (
    input  logic              CLK,
    input  logic              Begin,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_Addr,
    input  logic              Stop_Bit,
    input  logic              Jump_Bit,
    input  logic              Jump_Cond,
    input  logic [ADDR_W-1:0] Jump_Addr,
`ifdef MB_SINGLE_STEP_EN
    input  logic              Step_Mode,
    input  logic              Step,
`endif
    output logic [ADDR_W-1:0] ROM_Addr,
    output logic              Running,
    output logic              Done,
    output logic              LDAB,
    output logic [CNT_W-1:0]  Instr_Count
);
    mb_state_t state;
    logic adv, exec, stop, jump, incr;

`ifdef MB_SINGLE_STEP_EN
    assign adv = !Step_Mode || Step;
`else
    assign adv = 1'b1;
`endif
    // Start outranks every microword field, so it is excluded from exec
    assign exec = state == MB_RUN && adv && !Start;
    assign stop = exec && Stop_Bit;
    assign jump = exec && !Stop_Bit && Jump_Bit && Jump_Cond;
    assign incr = exec && !Stop_Bit && !(Jump_Bit && Jump_Cond);
    assign Running = state == MB_RUN;

    mb_upc_counter #(.ADDR_W(ADDR_W)) u_upc (
        .clk       (CLK),
        .rst       (Begin),
        .load      (Start || jump),
        .inc       (incr),
        .load_addr (Start ? Start_Addr : Jump_Addr),
        .addr      (ROM_Addr)
    );

    always_ff @(posedge CLK) begin
        if (Begin) begin
            state       <= MB_IDLE;
            Done        <= 1'b0;
            LDAB        <= 1'b0;
            Instr_Count <= '0;
        end else begin
            Done <= stop;
            LDAB <= jump;
            if (Start) begin
                state       <= MB_RUN;
                Instr_Count <= '0;
            end else if (exec) begin
                state       <= stop ? MB_IDLE : MB_RUN;
                Instr_Count <= &Instr_Count ? Instr_Count : Instr_Count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mb_sequencer.sv
// tb_mb_sequencer: directed plus randomized checks of mb_sequencer against a ROM-level behavioural model
module tb_mb_sequencer;
    logic       CLK = 1'b0;
    logic       Begin, Start, Stop_Bit, Jump_Bit, Jump_Cond;
    logic [7:0] Start_Addr, Jump_Addr, ROM_Addr;
    logic       Running, Done, LDAB;
    logic [11:0] Instr_Count;
    logic       Step_Mode = 1'b0, Step = 1'b0;

    logic       rom_stop [256];
    logic       rom_jmp  [256];
    logic       rom_cond [256];
    logic [7:0] rom_ja   [256];

    int m_pc, m_cnt, n_checks, n_fail;
    bit m_run, m_done, m_ldab;

    always #5 CLK = ~CLK;

    mb_sequencer dut (
        .CLK(CLK), .Begin(Begin), .Start(Start), .Start_Addr(Start_Addr),
        .Stop_Bit(Stop_Bit), .Jump_Bit(Jump_Bit), .Jump_Cond(Jump_Cond), .Jump_Addr(Jump_Addr),
`ifdef MB_SINGLE_STEP_EN
        .Step_Mode(Step_Mode), .Step(Step),
`endif
        .ROM_Addr(ROM_Addr), .Running(Running), .Done(Done), .LDAB(LDAB), .Instr_Count(Instr_Count)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom_stop[i] = 0; rom_jmp[i] = 0; rom_cond[i] = 0; rom_ja[i] = 8'h00;
        end
    endtask

    // One clock: drive the word at the model's PC, advance the model, compare all outputs
    task automatic cycle(input bit b, input bit s, input logic [7:0] sa);
        bit adv;
        Begin = b; Start = s; Start_Addr = sa;
        Stop_Bit = rom_stop[m_pc]; Jump_Bit = rom_jmp[m_pc];
        Jump_Cond = rom_cond[m_pc]; Jump_Addr = rom_ja[m_pc];
`ifdef MB_SINGLE_STEP_EN
        adv = !Step_Mode || Step;
`else
        adv = 1;
`endif
        @(posedge CLK);
        m_done = 0; m_ldab = 0;
        if (b) begin
            m_run = 0; m_pc = 0; m_cnt = 0;
        end else if (s) begin
            m_run = 1; m_pc = sa; m_cnt = 0;
        end else if (m_run && adv) begin
            m_cnt = (m_cnt == 4095) ? 4095 : m_cnt + 1;
            if (rom_stop[m_pc]) begin
                m_run = 0; m_done = 1;
            end else if (rom_jmp[m_pc] && rom_cond[m_pc]) begin
                m_pc = rom_ja[m_pc]; m_ldab = 1;
            end else
                m_pc = (m_pc + 1) % 256;
        end
        #1;
        check("rom_addr", ROM_Addr, m_pc);
        check("running", Running, m_run);
        check("done", Done, m_done);
        check("ldab", LDAB, m_ldab);
        check("instr_count", Instr_Count, m_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_ldab = 0;
        clear_rom();
        cycle(1, 0, 8'h00);
        cycle(1, 1, 8'h77);
        check("reset_addr", ROM_Addr, 0);

        // Begin mid-run at 0x23 with Start and STOP fields asserted
        cycle(0, 1, 8'h20);
        idle(3);
        check("at_23", ROM_Addr, 8'h23);
        rom_stop[8'h23] = 1; rom_jmp[8'h23] = 1; rom_cond[8'h23] = 1; rom_ja[8'h23] = 8'h99;
        cycle(1, 1, 8'h55);
        cycle(1, 0, 8'h00);
        check("begin_running", Running, 0);
        idle(3);
        check("begin_ignored", ROM_Addr, 0);

        // STOP at 0x13
        clear_rom();
        rom_stop[8'h13] = 1;
        cycle(0, 1, 8'h10);
        idle(4);
        check("stop_done", Done, 1);
        check("stop_count", Instr_Count, 4);
        idle(2);
        check("stop_hold_cnt", Instr_Count, 4);

        // Taken jump, then not-taken jump
        clear_rom();
        rom_jmp[8'h21] = 1; rom_cond[8'h21] = 1; rom_ja[8'h21] = 8'h40;
        rom_stop[8'h40] = 1; rom_stop[8'h22] = 1;
        cycle(0, 1, 8'h20);
        idle(2);
        check("jump_addr", ROM_Addr, 8'h40);
        check("jump_ldab", LDAB, 1);
        idle(2);
        check("jump_count", Instr_Count, 3);
        rom_cond[8'h21] = 0;
        cycle(0, 1, 8'h20);
        idle(2);
        check("nojump_addr", ROM_Addr, 8'h22);
        idle(2);

        // Wrap 0xFF -> 0x00
        clear_rom();
        rom_stop[8'h01] = 1;
        cycle(0, 1, 8'hFE);
        idle(2);
        check("wrap_addr", ROM_Addr, 8'h00);
        idle(2);
        check("wrap_count", Instr_Count, 4);

        // Restart colliding with STOP
        clear_rom();
        rom_stop[8'h52] = 1;
        cycle(0, 1, 8'h50);
        idle(2);
        cycle(0, 1, 8'h80);
        check("restart_addr", ROM_Addr, 8'h80);
        check("restart_done", Done, 0);
        check("restart_count", Instr_Count, 0);
        cycle(1, 0, 8'h00);

`ifdef MB_SINGLE_STEP_EN
        clear_rom();
        Step_Mode = 1;
        cycle(0, 1, 8'h30);
        for (int i = 0; i < 12; i++) begin
            Step = (i % 3 == 2);
            cycle(0, 0, 8'h00);
        end
        Step = 0;
        check("step_count", Instr_Count, 4);
        check("step_addr", ROM_Addr, 8'h34);
        Step_Mode = 0;
`endif

        // Randomized ROM and control traffic
        for (int i = 0; i < 256; i++) begin
            rom_stop[i] = ($urandom_range(15) == 0);
            rom_jmp[i]  = ($urandom_range(3) == 0);
            rom_cond[i] = $urandom_range(1);
            rom_ja[i]   = 8'($urandom);
        end
        for (int i = 0; i < 3000; i++) begin
`ifdef MB_SINGLE_STEP_EN
            Step_Mode = ($urandom_range(7) == 0) ? ~Step_Mode : Step_Mode;
            Step = $urandom_range(1);
`endif
            cycle($urandom_range(199) == 0, $urandom_range(24) == 0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
